// File: rtl/mux_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_share_arbiter
// Purpose  : Round-robin owner of a shared 2:1 mux. It registers the grant,
//            the select line and the selected data word with a valid flag.
//            Define MUX_ARB_TIMEOUT_EN to enable a forced handoff after
//            MAX_HOLD cycles of ownership.
// Revision : 1.0 - initial release
// ============================================================================
module mux_share_arbiter #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [DATA_W-1:0] I0,
   input  logic [DATA_W-1:0] I1,
   output logic [1:0]        grant,
   output logic              selection,
   output logic [DATA_W-1:0] Y,
   output logic              y_valid
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_hold_range_check
      $error("mux_share_arbiter: MAX_HOLD must be within 2..255");
   end

   state_t              state_q;
   state_t              state_d;
   logic                last_q;
   logic [1:0]          grant_q;
   logic                sel_q;
   logic [DATA_W-1:0]   y_q;
   logic                valid_q;
   logic                timeout_w;

`ifdef MUX_ARB_TIMEOUT_EN
   localparam logic [7:0] C_HOLD_MAX = 8'(MAX_HOLD - 1);

   logic [7:0] hold_q;
   logic [7:0] hold_d;

   // Counter restarts on every change of owner and saturates while held.
   always_comb begin
      hold_d = 8'd0;
      if ((state_d != ST_IDLE) && (state_d == state_q)) begin
         hold_d = (hold_q == C_HOLD_MAX) ? hold_q : hold_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q <= 8'd0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign timeout_w = (hold_q == C_HOLD_MAX);
`else
   assign timeout_w = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            case (req)
               2'b01:   state_d = ST_OWN0;
               2'b10:   state_d = ST_OWN1;
               2'b11:   state_d = last_q ? ST_OWN0 : ST_OWN1;
               default: state_d = ST_IDLE;
            endcase
         end
         ST_OWN0: begin
            if (!req[0] || (timeout_w && req[1])) begin
               state_d = req[1] ? ST_OWN1 : ST_IDLE;
            end
         end
         ST_OWN1: begin
            if (!req[1] || (timeout_w && req[0])) begin
               state_d = req[0] ? ST_OWN0 : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Data is captured through the select that was registered last cycle,
   // so Y always reflects the owner that held the path on the sampling edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         grant_q <= 2'b00;
         sel_q   <= 1'b0;
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= {state_d == ST_OWN1, state_d == ST_OWN0};
         if (state_d != ST_IDLE) begin
            sel_q  <= (state_d == ST_OWN1);
            last_q <= (state_d == ST_OWN1);
         end
         valid_q <= (state_q != ST_IDLE);
         if (state_q != ST_IDLE) begin
            y_q <= sel_q ? I1 : I0;
         end
      end
   end

   assign grant     = grant_q;
   assign selection = sel_q;
   assign Y         = y_q;
   assign y_valid   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_share_arbiter
// Purpose  : Directed and randomized checks of mux_share_arbiter against an
//            owner/last-pointer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_share_arbiter;

   localparam int DW = 8;
   localparam int MH = 4;
`ifdef MUX_ARB_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    req;
   logic [DW-1:0] I0;
   logic [DW-1:0] I1;
   logic [1:0]    grant;
   logic          selection;
   logic [DW-1:0] Y;
   logic          y_valid;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: owner is -1 when nobody holds the path.
   int            m_owner;
   int            m_last;
   int            m_hold;
   logic          m_sel;
   logic [DW-1:0] m_y;
   logic          m_valid;

   always #5 clk = ~clk;

   mux_share_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .I0        (I0),
      .I1        (I1),
      .grant     (grant),
      .selection (selection),
      .Y         (Y),
      .y_valid   (y_valid)
   );

   function automatic logic [1:0] m_grant();
      if (m_owner < 0) return 2'b00;
      return (m_owner == 0) ? 2'b01 : 2'b10;
   endfunction

   task automatic model_edge();
      int  nxt;
      bit  tmo_fire;
      if (reset) begin
         m_owner = -1; m_last = 1; m_hold = 0;
         m_sel = 1'b0; m_y = '0; m_valid = 1'b0;
         return;
      end
      m_valid = (m_owner >= 0);
      if (m_owner >= 0) m_y = m_sel ? I1 : I0;
      tmo_fire = TMO && (m_hold == MH - 1);
      if (m_owner < 0) begin
         case (req)
            2'b00:   nxt = -1;
            2'b01:   nxt = 0;
            2'b10:   nxt = 1;
            default: nxt = 1 - m_last;
         endcase
      end else if (req[m_owner] && !(tmo_fire && req[1 - m_owner])) begin
         nxt = m_owner;
      end else if (req[1 - m_owner]) begin
         nxt = 1 - m_owner;
      end else begin
         nxt = -1;
      end
      if (nxt < 0)             m_hold = 0;
      else if (nxt == m_owner) m_hold = (m_hold + 1 > MH - 1) ? MH - 1 : m_hold + 1;
      else                     m_hold = 0;
      if (nxt >= 0) begin
         m_sel  = (nxt == 1);
         m_last = nxt;
      end
      m_owner = nxt;
   endtask

   // Inputs change on the falling edge; outputs are inspected on the next one.
   task automatic step(input logic rst_v, input logic [1:0] r,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
      reset = rst_v; req = r; I0 = a; I1 = b;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(1'b1, 2'b11, 8'hFF, 8'hFF);
      step(1'b1, 2'b11, 8'hFF, 8'hFF);
      n_checks++;
      if ({grant, selection} !== 3'b000) begin
         n_fail++; $display("FAIL reset_grant_sel: got %b_%b expected 00_0", grant, selection);
      end
      n_checks++;
      if ({Y, y_valid} !== {8'h00, 1'b0}) begin
         n_fail++; $display("FAIL reset_data: got Y=%h v=%b expected Y=00 v=0", Y, y_valid);
      end
   endtask

   task automatic test_first_tie();
      step(1'b1, 2'b00, 8'h00, 8'h00);
      step(1'b0, 2'b11, 8'hA5, 8'h5A);
      n_checks++;
      if ({grant, selection, y_valid} !== 4'b01_0_0) begin
         n_fail++; $display("FAIL first_tie_grant: got g=%b s=%b v=%b expected g=01 s=0 v=0",
                            grant, selection, y_valid);
      end
      step(1'b0, 2'b11, 8'hA5, 8'h5A);
      n_checks++;
      if ({Y, y_valid} !== {8'hA5, 1'b1}) begin
         n_fail++; $display("FAIL first_tie_data: got Y=%h v=%b expected Y=a5 v=1", Y, y_valid);
      end
   endtask

   task automatic test_handoff();
      step(1'b1, 2'b00, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 2'b01, 8'hA5, 8'h3C);
         if (i >= 1) begin
            n_checks++;
            if ({grant, y_valid} !== 3'b01_1) begin
               n_fail++; $display("FAIL handoff_own0[%0d]: got g=%b v=%b expected g=01 v=1", i, grant, y_valid);
            end
         end
      end
      step(1'b0, 2'b10, 8'hA5, 8'h3C);
      n_checks++;
      if ({grant, selection, y_valid, Y} !== {2'b10, 1'b1, 1'b1, 8'hA5}) begin
         n_fail++; $display("FAIL handoff_edge: got g=%b s=%b v=%b Y=%h expected g=10 s=1 v=1 Y=a5",
                            grant, selection, y_valid, Y);
      end
      step(1'b0, 2'b10, 8'hA5, 8'h3C);
      n_checks++;
      if ({Y, y_valid} !== {8'h3C, 1'b1}) begin
         n_fail++; $display("FAIL handoff_data: got Y=%h v=%b expected Y=3c v=1", Y, y_valid);
      end
   endtask

   task automatic test_alternating_tie();
      logic [1:0] exp_g;
      step(1'b1, 2'b00, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         step(1'b0, 2'b11, 8'($urandom), 8'($urandom));
         n_checks++;
         if (grant !== exp_g) begin
            n_fail++; $display("FAIL alt_tie[%0d]: got %b expected %b", i, grant, exp_g);
         end
         step(1'b0, 2'b00, 8'($urandom), 8'($urandom));
         step(1'b0, 2'b00, 8'($urandom), 8'($urandom));
      end
   endtask

   task automatic test_hold_limit();
      logic [1:0] exp_g;
      step(1'b1, 2'b00, 8'h00, 8'h00);
      for (int i = 0; i < 13; i++) begin
         step(1'b0, 2'b11, 8'($urandom), 8'($urandom));
         if (TMO) exp_g = ((i / MH) % 2 == 0) ? 2'b01 : 2'b10;
         else     exp_g = 2'b01;
         n_checks++;
         if ({grant, y_valid} !== {exp_g, (i != 0)}) begin
            n_fail++; $display("FAIL hold_limit[%0d]: got g=%b v=%b expected g=%b v=%b",
                               i, grant, y_valid, exp_g, (i != 0));
         end
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 2'b00, 8'h00, 8'h00);
      step(1'b0, 2'b10, 8'h11, 8'h3C);
      step(1'b0, 2'b10, 8'h11, 8'h3C);
      n_checks++;
      if ({grant, Y, y_valid} !== {2'b10, 8'h3C, 1'b1}) begin
         n_fail++; $display("FAIL rst_mid_pre: got g=%b Y=%h v=%b expected g=10 Y=3c v=1", grant, Y, y_valid);
      end
      step(1'b1, 2'b10, 8'h11, 8'h3C);
      n_checks++;
      if ({grant, selection, Y, y_valid} !== {2'b00, 1'b0, 8'h00, 1'b0}) begin
         n_fail++; $display("FAIL rst_mid_clear: got g=%b s=%b Y=%h v=%b expected g=00 s=0 Y=00 v=0",
                            grant, selection, Y, y_valid);
      end
      step(1'b0, 2'b11, 8'h11, 8'h3C);
      n_checks++;
      if ({grant, Y, y_valid} !== {2'b01, 8'h00, 1'b0}) begin
         n_fail++; $display("FAIL rst_mid_after: got g=%b Y=%h v=%b expected g=01 Y=00 v=0", grant, Y, y_valid);
      end
   endtask

   task automatic test_idle_hold();
      step(1'b1, 2'b00, 8'h00, 8'h00);
      step(1'b0, 2'b01, 8'h5A, 8'h77);
      step(1'b0, 2'b01, 8'h5A, 8'h77);
      step(1'b0, 2'b00, 8'h5A, 8'h77);
      n_checks++;
      if ({grant, y_valid, Y} !== {2'b00, 1'b1, 8'h5A}) begin
         n_fail++; $display("FAIL idle_release: got g=%b v=%b Y=%h expected g=00 v=1 Y=5a", grant, y_valid, Y);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 2'b00, 8'($urandom), 8'($urandom));
         n_checks++;
         if ({grant, y_valid, Y} !== {2'b00, 1'b0, 8'h5A}) begin
            n_fail++; $display("FAIL idle_hold[%0d]: got g=%b v=%b Y=%h expected g=00 v=0 Y=5a",
                               i, grant, y_valid, Y);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] r;
      logic       rs;
      r = 2'b00;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 3) r = 2'($urandom_range(0, 3));
         rs = ($urandom_range(0, 49) == 0);
         step(rs, r, 8'($urandom), 8'($urandom));
         n_checks++;
         if ({grant, selection, Y, y_valid} !== {m_grant(), m_sel, m_y, m_valid}) begin
            n_fail++; $display("FAIL random[%0d]: got g=%b s=%b Y=%h v=%b expected g=%b s=%b Y=%h v=%b",
                               i, grant, selection, Y, y_valid, m_grant(), m_sel, m_y, m_valid);
         end
      end
   endtask

   initial begin
      reset = 1'b1; req = 2'b00; I0 = '0; I1 = '0;
      @(negedge clk);
      test_reset();
      test_first_tie();
      test_handoff();
      test_alternating_tie();
      test_hold_limit();
      test_reset_mid();
      test_idle_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
